// File: rtl/serial_sub.sv
// serial_sub: multi-cycle subtractor computing {bout, diff} = a - b - bin,
// STEP bits per clock, least-significant chunk first, with a registered
// borrow chain between chunks. Start/done handshake, synchronous reset.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf.
module serial_sub #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject unusable geometries while elaborating.
  if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
    $error("serial_sub: WIDTH must be >= 2 and a multiple of STEP >= 1");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             br;
  logic [CW-1:0]    count;
  logic [STEP:0]    step_sum;
  logic [STEP-1:0]  chunk;
  logic             t;
  logic [WIDTH-1:0] res_next;
  logic             accept, step, last;

  // One chunk of subtraction at STEP+1 bits; the top bit is the borrow out.
  always_comb begin
    step_sum = {1'b0, a_sh[STEP-1:0]} - {1'b0, b_sh[STEP-1:0]} - {{STEP{1'b0}}, br};
  end

  assign chunk = step_sum[STEP-1:0];
  assign t     = step_sum[STEP];

  // Result accumulator: each new chunk enters at the MSB end, so after N
  // steps the first (least-significant) chunk has reached bit 0.
  if (N == 1) begin : g_single
    assign res_next = chunk;
  end else begin : g_multi
    logic [WIDTH-STEP-1:0] acc;

    // Keep the chunks produced so far; only the upper WIDTH-STEP bits survive a shift.
    always_ff @(posedge clk) begin
      if (rst)       acc <= '0;
      else if (step) acc <= res_next[WIDTH-1:STEP];
    end

    assign res_next = {chunk, acc};
  end

  // Next-state and step control for the IDLE/RUN sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count == LAST) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand shifters, borrow chain, step counter and the held result outputs.
  always_ff @(posedge clk) begin
    // NOTE: reset clears every register here, including the operand shifters, so nothing stale survives an abandoned run.
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
      count <= '0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= last;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        br    <= bin;
        count <= '0;
      end else if (step) begin
        a_sh  <= a_sh >> STEP;
        b_sh  <= b_sh >> STEP;
        br    <= t;
        count <= count + 1'b1;
        if (last) begin
          diff <= res_next;
          bout <= t;
`ifdef SERIAL_SUB_OVF_EN
          // a^b^d at the MSB recovers the borrow into it; XOR with borrow out.
          ovf  <= a_sh[STEP-1] ^ b_sh[STEP-1] ^ chunk[STEP-1] ^ t;
`endif
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed checks of serial_sub in three geometries
// (8/1, 8/4, 16/2). Define SERIAL_SUB_OVF_EN to also check ovf.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst;

  logic        start8, bin8, busy8, done8, bout8;
  logic [7:0]  a8, b8, diff8;
  logic        start4, bin4, busy4, done4, bout4;
  logic [7:0]  a4, b4, diff4;
  logic        start16, bin16, busy16, done16, bout16;
  logic [15:0] a16, b16, diff16;
`ifdef SERIAL_SUB_OVF_EN
  logic        ovf8, ovf4, ovf16;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8), .STEP(1)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_sub #(.WIDTH(8), .STEP(4)) u84 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  serial_sub #(.WIDTH(16), .STEP(2)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf16)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic done_of(input int w);
    case (w)
      0:       return done8;
      1:       return done4;
      default: return done16;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy8;
      1:       return busy4;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [15:0] diff_of(input int w);
    case (w)
      0:       return {8'h00, diff8};
      1:       return {8'h00, diff4};
      default: return diff16;
    endcase
  endfunction

  function automatic logic bout_of(input int w);
    case (w)
      0:       return bout8;
      1:       return bout4;
      default: return bout16;
    endcase
  endfunction

  // Launch one operation on instance w, wait (bounded) for done, check result.
  // Returns in the done cycle, #1 after the completing edge.
  task automatic go(input int w, input logic [15:0] a, input logic [15:0] b,
                    input logic bin, input int lat, input logic [15:0] ed,
                    input logic eb, input string tag);
    int cyc;
    case (w)
      0:       begin a8  = a[7:0]; b8  = b[7:0]; bin8  = bin; start8  = 1'b1; end
      1:       begin a4  = a[7:0]; b4  = b[7:0]; bin4  = bin; start4  = 1'b1; end
      default: begin a16 = a;      b16 = b;      bin16 = bin; start16 = 1'b1; end
    endcase
    @(posedge clk); #1;
    start8 = 1'b0; start4 = 1'b0; start16 = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy_of(w)), 32'd1);
    cyc = 0;
    while (!done_of(w) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    check({tag, " busy_in_done"}, 32'(busy_of(w)), 32'd0);
    check({tag, " diff"}, 32'(diff_of(w)), 32'(ed));
    check({tag, " bout"}, 32'(bout_of(w)), 32'(eb));
  endtask

  initial begin
    int cyc;
    int ndone;
    logic [15:0] ra, rb, ed;
    logic        rbin, eb;

    rst = 1'b1;
    start8 = 1'b0; start4 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; bin8 = 1'b0;
    a4 = '0; b4 = '0; bin4 = 1'b0;
    a16 = '0; b16 = '0; bin16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy8), 32'd0);
    check("reset done", 32'(done8), 32'd0);
    check("reset diff", 32'(diff8), 32'd0);
    check("reset bout", 32'(bout8), 32'd0);
    check("reset busy w8s4", 32'(busy4), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", 32'(ovf8), 32'd0);
`endif
    rst = 1'b0;

    // Basic WIDTH=8, STEP=1 vectors.
    go(0, 16'h5A, 16'h3C, 1'b0, 8, 16'h1E, 1'b0, "5A-3C");
    @(posedge clk); #1;
    check("done one cycle", 32'(done8), 32'd0);
    go(0, 16'h00, 16'h01, 1'b1, 8, 16'hFE, 1'b1, "00-01-1");
    go(0, 16'hFF, 16'hFF, 1'b1, 8, 16'hFF, 1'b1, "FF-FF-1");
    go(0, 16'hFF, 16'h00, 1'b0, 8, 16'hFF, 1'b0, "FF-00");

    // start held high through a run with operands changed mid-run.
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'hAA; b8 = 8'h55;
    check("held busy", 32'(busy8), 32'd1);
    check("held diff hidden", 32'(diff8), 32'hFF);
    cyc = 0;
    while (!done8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("held latency", 32'(cyc), 32'd8);
    check("held diff", 32'(diff8), 32'h22);
    check("held bout", 32'(bout8), 32'd0);
    // start is still high in the done cycle, so the next edge accepts AA-55.
    @(posedge clk); #1;
    start8 = 1'b0;
    check("b2b busy", 32'(busy8), 32'd1);
    check("b2b diff held", 32'(diff8), 32'h22);
    cyc = 1;
    while (!done8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b spacing", 32'(cyc), 32'd9);
    check("b2b diff", 32'(diff8), 32'h55);
    check("b2b bout", 32'(bout8), 32'd0);

    // Reset mid-run abandons the operation.
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst busy", 32'(busy8), 32'd0);
    check("midrst done", 32'(done8), 32'd0);
    check("midrst diff", 32'(diff8), 32'd0);
    check("midrst bout", 32'(bout8), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    check("midrst no done", 32'(ndone), 32'd0);
    go(0, 16'h10, 16'h01, 1'b0, 8, 16'h0F, 1'b0, "after rst 10-01");

    // Signed-overflow vectors (results checked in every build).
    go(0, 16'h80, 16'h01, 1'b0, 8, 16'h7F, 1'b0, "80-01");
`ifdef SERIAL_SUB_OVF_EN
    check("80-01 ovf", 32'(ovf8), 32'd1);
`endif
    go(0, 16'h7F, 16'hFF, 1'b0, 8, 16'h80, 1'b1, "7F-FF");
`ifdef SERIAL_SUB_OVF_EN
    check("7F-FF ovf", 32'(ovf8), 32'd1);
`endif
    go(0, 16'h05, 16'h03, 1'b1, 8, 16'h01, 1'b0, "05-03-1");
`ifdef SERIAL_SUB_OVF_EN
    check("05-03-1 ovf", 32'(ovf8), 32'd0);
`endif

    // WIDTH=8, STEP=4.
    go(1, 16'h12, 16'h34, 1'b0, 2, 16'hDE, 1'b1, "w8s4 12-34");
    go(1, 16'hF0, 16'h0F, 1'b1, 2, 16'hE0, 1'b0, "w8s4 F0-0F-1");

    // WIDTH=16, STEP=2: directed corners, then random operands vs. a reference.
    go(2, 16'h1234, 16'h0FFF, 1'b0, 8, 16'h0235, 1'b0, "w16 1234-0FFF");
    go(2, 16'h0000, 16'h0000, 1'b1, 8, 16'hFFFF, 1'b1, "w16 0-0-1");
    go(2, 16'hFFFF, 16'h0001, 1'b1, 8, 16'hFFFD, 1'b0, "w16 FFFF-1-1");
    go(2, 16'h8000, 16'h8000, 1'b0, 8, 16'h0000, 1'b0, "w16 8000-8000");
    for (int i = 0; i < 6; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(1, 0));
      {eb, ed} = {1'b0, ra} - {1'b0, rb} - {16'h0000, rbin};
      go(2, ra, rb, rbin, 8, ed, eb, $sformatf("w16 rand%0d %h-%h-%0d", i, ra, rb, rbin));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
# serial_sub

Parametrised multi-cycle subtractor: computes `{bout, diff} = a - b - bin` over a WIDTH-bit operand pair, STEP bits per clock, using a registered borrow chain. It is the sequential, width-generic successor to the single-bit full-subtractor cell. It sits in datapaths where a full WIDTH-bit ripple subtractor is too slow or too large, and it exchanges operands and results with a start/done handshake.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2.
- STEP, 1, bits processed per clock; must be ≥ 1 and divide WIDTH. A violation is an elaboration error.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result registers update.
- diff  output  WIDTH  result difference; held until the next completion.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- N = WIDTH/STEP steps per operation.
- State machine:
  - IDLE → RUN on start=1. On that edge, load shift registers A=a and B=b, set the borrow register br=bin, and clear the step counter.
  - RUN → RUN while count < N−1. Each edge handles one chunk, LSB chunk first:
    - `{t, chunk} = {1'b0, A[STEP-1:0]} - {1'b0, B[STEP-1:0]} - br`, computed at STEP+1 bits.
    - br ← t.
    - A and B shift right by STEP.
    - chunk shifts into the internal result register from its MSB end.
    - count increments.
  - RUN → IDLE on the step edge where count = N−1. That edge also:
    - loads diff with the completed result and bout with the final borrow;
    - sets done=1 for exactly one cycle.
- Result: `{bout, diff} ≡ a − b − bin mod 2^(WIDTH+1)`, with a and b unsigned and zero-extended.
- diff and bout change only on completion edges. Internal shifting is never visible on the ports.
- start while busy=1 is ignored; operands are not re-sampled.
- start in the cycle done=1 is accepted, because the FSM is already in IDLE. Back-to-back throughput is one result per N+1 cycles.
- a, b and bin may change freely after the accepting edge.
- rst=1 at any edge, including mid-RUN:
  - state → IDLE; the operation is abandoned and no done pulse follows.
  - busy=0, done=0, diff=0, bout=0, ovf=0; internal registers cleared.
- rst takes priority over start on the same edge.

## Timing
- Accepting edge E0. busy is 1 from after E0 through the edge EN; it goes 0 in the cycle done=1.
- Step edges E1..EN. done=1 and new diff/bout are visible in the cycle after EN.
- Latency from the start edge to the done cycle is N clocks. Examples: WIDTH=8, STEP=1 → 8; WIDTH=8, STEP=4 → 2.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - ovf is a port.
  - On completion, ovf = 1 iff the signed (two's-complement) value a − b − bin lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Equivalently, ovf = the borrow into the MSB XOR the borrow out of the MSB, captured during the final step.
  - ovf is held with diff and cleared by reset.
- SERIAL_SUB_OVF_EN undefined: no ovf port and no overflow logic. All other behaviour is identical.

## Test plan
- WIDTH=8, STEP=1; a=0x5A, b=0x3C, bin=0, start pulse → busy for 8 cycles, then done=1 for one cycle, diff=0x1E, bout=0.
- a=0x00, b=0x01, bin=1 → diff=0xFE, bout=1. Then a=0xFF, b=0xFF, bin=1 → diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=0 → diff=0xFF, bout=0.
- start held high for the whole operation with a, b changed mid-RUN → a single result for the originally captured operands. A new operation is accepted in the done cycle, and the second done comes N+1 cycles after the first.
- rst asserted at step 4 of a run → busy=0 and diff=bout=0 on the next cycle, no done pulse. A following start with a=0x10, b=0x01 → diff=0x0F.
- WIDTH=8, STEP=4; a=0x12, b=0x34, bin=0 → done 2 cycles after start, diff=0xDE, bout=1. WIDTH=16, STEP=2, random operand sweep compared against a reference model.
- With SERIAL_SUB_OVF_EN, WIDTH=8:
  - a=0x80, b=0x01, bin=0 → diff=0x7F, ovf=1.
  - a=0x7F, b=0xFF, bin=0 → diff=0x80, ovf=1.
  - a=0x05, b=0x03, bin=1 → diff=0x01, ovf=0.
